// File: rtl/player_input_pkg.sv
// Shared constants for the player input mapper: action indices, the power-on
// keymap and the combo detector state encoding.
package player_input_pkg;

    localparam int ACT_FORWARD = 0;
    localparam int ACT_BACK    = 1;
    localparam int ACT_PUNCH   = 2;
    localparam int ACT_SQUAT   = 3;
    localparam int ACT_KICK    = 4;
    localparam int ACT_JUMP    = 5;

    localparam int DEF_PLAYERS = 2;
    localparam int DEF_ACTIONS = 6;

    localparam logic [7:0] DEFAULT_KEYMAP [DEF_PLAYERS][DEF_ACTIONS] = '{
        '{8'h07, 8'h04, 8'h0D, 8'h16, 8'h0E, 8'h1A},
        '{8'h4F, 8'h50, 8'h59, 8'h51, 8'h5A, 8'h52}
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        FWD  = 2'd2
    } combo_state_e;

    // Players and actions beyond the built-in table power up unbound.
    function automatic logic [7:0] default_code(input int p, input int a);
        if (p < DEF_PLAYERS && a < DEF_ACTIONS) begin
            return DEFAULT_KEYMAP[p][a];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/player_input_mapper_combo_fsm.sv
// Per-player squat -> forward -> punch combo detector, stepped once per frame.
// state | meaning
// IDLE  | waiting for a squat press
// DOWN  | squat seen, waiting for forward within the window
// FWD   | forward seen, waiting for punch within the window
module combo_fsm
    import player_input_pkg::*;
#(
    parameter int COMBO_WINDOW = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic update,
    input  logic press_squat,
    input  logic press_forward,
    input  logic press_punch,
    output logic special
);

    localparam int CW = $clog2(COMBO_WINDOW + 1);

    combo_state_e   state, state_next;
    logic [CW-1:0]  remain, remain_next;
    logic           hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            remain  <= '0;
            special <= 1'b0;
        end else if (update) begin
            state   <= state_next;
            remain  <= remain_next;
            special <= hit;
        end
    end

    // Squat has priority so a single frame advances at most one step.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        if (press_squat) begin
            state_next  = DOWN;
            remain_next = CW'(COMBO_WINDOW);
        end else begin
            case (state)
                DOWN: begin
                    if (press_forward) begin
                        state_next  = FWD;
                        remain_next = CW'(COMBO_WINDOW);
                    end else if (remain == CW'(1)) begin
                        state_next = IDLE;
                    end else begin
                        remain_next = remain - 1'b1;
                    end
                end
                FWD: begin
                    if (press_punch) begin
                        state_next = IDLE;
                    end else if (remain == CW'(1)) begin
                        state_next = IDLE;
                    end else begin
                        remain_next = remain - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hit = (state == FWD) && press_punch && !press_squat;
    end

endmodule

// File: rtl/player_input_mapper.sv
// Maps USB HID keycodes to per-player action bits once per video frame.
// Optional combo detection is built when PLAYER_INPUT_COMBO_EN is defined.
module player_input_mapper
    import player_input_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_ACTIONS  = 6,
    parameter int NUM_SLOTS    = 6,
    parameter int COMBO_WINDOW = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 frame_tick,
    input  logic [31:0]                          keycode_word0,
    input  logic [31:0]                          keycode_word1,
    input  logic                                 map_we,
    input  logic [$clog2(NUM_PLAYERS)-1:0]       map_player,
    input  logic [$clog2(NUM_ACTIONS)-1:0]       map_action,
    input  logic [7:0]                           map_code,
    output logic [NUM_PLAYERS*NUM_ACTIONS-1:0]   act_level,
    output logic [NUM_PLAYERS*NUM_ACTIONS-1:0]   act_press,
    output logic [NUM_PLAYERS*NUM_ACTIONS-1:0]   act_release,
    output logic [NUM_PLAYERS-1:0]               special,
    output logic                                 frame_strobe
);

    localparam int NB = NUM_PLAYERS * NUM_ACTIONS;

    logic          tick_s1, tick_s2, tick_s3, frame_pulse;
    logic [7:0]    keymap [NUM_PLAYERS][NUM_ACTIONS];
    logic [63:0]   slots;
    logic [NB-1:0] raw, resolved;

    assign slots = {keycode_word1, keycode_word0};

    if (NUM_SLOTS < 8) begin : g_unused_slots
        logic unused_hi_bytes;
        assign unused_hi_bytes = ^slots[63:8*NUM_SLOTS];
    end

    // frame_tick comes from the 25 MHz domain: two flops, then edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_s1     <= 1'b0;
            tick_s2     <= 1'b0;
            tick_s3     <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            tick_s1     <= frame_tick;
            tick_s2     <= tick_s1;
            tick_s3     <= tick_s2;
            frame_pulse <= tick_s2 & ~tick_s3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int a = 0; a < NUM_ACTIONS; a++) begin
                    keymap[p][a] <= default_code(p, a);
                end
            end
        end else if (map_we) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int a = 0; a < NUM_ACTIONS; a++) begin
                    if (int'(map_player) == p && int'(map_action) == a) begin
                        keymap[p][a] <= map_code;
                    end
                end
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (keymap[p][a] != 8'h00 && slots[8*s +: 8] == keymap[p][a]) begin
                        raw[p*NUM_ACTIONS + a] = 1'b1;
                    end
                end
            end
        end
        // Opposing directions cancel; squat beats jump.
        resolved = raw;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (raw[p*NUM_ACTIONS + ACT_FORWARD] && raw[p*NUM_ACTIONS + ACT_BACK]) begin
                resolved[p*NUM_ACTIONS + ACT_FORWARD] = 1'b0;
                resolved[p*NUM_ACTIONS + ACT_BACK]    = 1'b0;
            end
            if (raw[p*NUM_ACTIONS + ACT_SQUAT] && raw[p*NUM_ACTIONS + ACT_JUMP]) begin
                resolved[p*NUM_ACTIONS + ACT_JUMP] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_level    <= '0;
            act_press    <= '0;
            act_release  <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= frame_pulse;
            if (frame_pulse) begin
                act_level   <= resolved;
                act_press   <= resolved & ~act_level;
                act_release <= ~resolved & act_level;
            end
        end
    end

`ifdef PLAYER_INPUT_COMBO_EN
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_combo
        combo_fsm #(
            .COMBO_WINDOW (COMBO_WINDOW)
        ) u_combo (
            .clk           (clk),
            .reset_n       (reset_n),
            .update        (frame_pulse),
            .press_squat   (resolved[p*NUM_ACTIONS + ACT_SQUAT]   & ~act_level[p*NUM_ACTIONS + ACT_SQUAT]),
            .press_forward (resolved[p*NUM_ACTIONS + ACT_FORWARD] & ~act_level[p*NUM_ACTIONS + ACT_FORWARD]),
            .press_punch   (resolved[p*NUM_ACTIONS + ACT_PUNCH]   & ~act_level[p*NUM_ACTIONS + ACT_PUNCH]),
            .special       (special[p])
        );
    end
`else
    assign special = '0;
`endif

endmodule
